// File: rtl/rf_writeback_queue.sv
// Writeback queue: buffers ALU/load results and drains one register-file write per cycle.
// Optional macro RF_WBQ_BYPASS_EN builds the youngest-pending-write bypass data path on chk_data.
module rf_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [AW-1:0]                alu_addr,
  input  logic [DW-1:0]                alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_addr,
  input  logic [DW-1:0]                mem_data,
  input  logic                         wb_hold,
  output logic [AW-1:0]                Awr,
  output logic [DW-1:0]                Din,
  output logic                         WrEn,
  input  logic [AW-1:0]                Ard_chk,
  output logic                         chk_pending,
  output logic [DW-1:0]                chk_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [DEPTH-1:0] fifo_hit;
  logic          out_hit;

  // Memory stage wins arbitration; full uses registered occupancy only.
  always_comb begin
    sel_addr  = mem_valid ? mem_addr : alu_addr;
    sel_data  = mem_valid ? mem_data : alu_data;
    full      = (count == CW'(DEPTH));
    mem_ready = ~full;
    alu_ready = ~full & ~mem_valid;
    push      = ~full & (mem_valid | alu_valid) & (sel_addr != '0);
    pop       = (count != '0) & ~wb_hold;
  end

  // Entry storage carries no reset; validity comes from pointers and count.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= sel_addr;
      data_mem[wr_ptr] <= sel_data;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      WrEn   <= 1'b0;
      Awr    <= '0;
      Din    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        Awr    <= addr_mem[rd_ptr];
        Din    <= data_mem[rd_ptr];
      end
      WrEn  <= pop;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    fifo_hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rd_ptr;
      fifo_hit[i] = (CW'(off) < count) && (addr_mem[PW'(i)] == Ard_chk);
    end
    out_hit     = WrEn && (Awr == Ard_chk);
    chk_pending = (Ard_chk != '0) && ((|fifo_hit) || out_hit);
  end

`ifdef RF_WBQ_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    chk_data = '0;
    if (Ard_chk != '0) begin
      if (out_hit) chk_data = Din;
      for (int k = 0; k < int'(DEPTH); k++) begin
        logic [PW-1:0] idx;
        idx = rd_ptr + PW'(k);
        if (fifo_hit[idx]) chk_data = data_mem[idx];
      end
    end
  end
`else
  assign chk_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: per-cycle vector table plus an async-reset sequence.
module tb_rf_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          Clk;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          wb_hold;
  logic [AW-1:0] Awr;
  logic [DW-1:0] Din;
  logic          WrEn;
  logic [AW-1:0] Ard_chk;
  logic          chk_pending;
  logic [DW-1:0] chk_data;
  logic [CW-1:0] count;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_hold(wb_hold), .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .Ard_chk(Ard_chk), .chk_pending(chk_pending), .chk_data(chk_data), .count(count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          hold;
    logic [AW-1:0] chk;
    logic          ear;
    logic          emr;
    logic [CW-1:0] ecnt;
    logic          ewe;
    logic [AW-1:0] eawr;
    logic [DW-1:0] edin;
    logic          epend;
    logic [DW-1:0] ecd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                              input logic hold, input logic [AW-1:0] chk,
                              input logic ear, input logic emr, input logic [CW-1:0] ecnt,
                              input logic ewe, input logic [AW-1:0] eawr, input logic [DW-1:0] edin,
                              input logic epend, input logic [DW-1:0] ecd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.hold = hold; v.chk = chk; v.ear = ear; v.emr = emr; v.ecnt = ecnt;
    v.ewe = ewe; v.eawr = eawr; v.edin = edin; v.epend = epend; v.ecd = ecd;
    return v;
  endfunction

  // Idle cycle: no requests, both readies expected high.
  function automatic vec_t mki(input logic hold, input logic [AW-1:0] chk, input logic [CW-1:0] ecnt,
                               input logic ewe, input logic [AW-1:0] eawr, input logic [DW-1:0] edin,
                               input logic epend, input logic [DW-1:0] ecd);
    return mk(0, 0, 0, 0, 0, 0, hold, chk, 1, 1, ecnt, ewe, eawr, edin, epend, ecd);
  endfunction

  function automatic logic [DW-1:0] exp_bypass(input logic [DW-1:0] d);
`ifdef RF_WBQ_BYPASS_EN
    return d;
`else
    return (d == d) ? '0 : '0;
`endif
  endfunction

  task automatic drive_idle();
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0;
  endtask

  initial begin
    // Each row: inputs applied for one cycle, outputs expected during that cycle (before the edge).
    // single ALU write, latency and one-cycle WrEn
    vecs.push_back(mk(1, 5, 'hA5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mki(0, 5, 1, 0, 0, 0, 1, 'hA5));
    vecs.push_back(mki(0, 5, 0, 1, 5, 'hA5, 1, 'hA5));
    vecs.push_back(mki(0, 5, 0, 0, 5, 'hA5, 0, 0));
    // mem priority over ALU
    vecs.push_back(mk(1, 4, 'h44, 1, 3, 'h33, 0, 0, 0, 1, 0, 0, 5, 'hA5, 0, 0));
    vecs.push_back(mk(1, 4, 'h44, 0, 0, 0, 0, 3, 1, 1, 1, 0, 5, 'hA5, 1, 'h33));
    vecs.push_back(mki(0, 4, 1, 1, 3, 'h33, 1, 'h44));
    vecs.push_back(mki(0, 4, 0, 1, 4, 'h44, 1, 'h44));
    vecs.push_back(mki(0, 4, 0, 0, 4, 'h44, 0, 0));
    // fill under hold, full back-pressure, ordered drain
    vecs.push_back(mk(1, 1, 'h101, 0, 0, 0, 1, 0, 1, 1, 0, 0, 4, 'h44, 0, 0));
    vecs.push_back(mk(1, 2, 'h102, 0, 0, 0, 1, 1, 1, 1, 1, 0, 4, 'h44, 1, 'h101));
    vecs.push_back(mk(1, 3, 'h103, 0, 0, 0, 1, 2, 1, 1, 2, 0, 4, 'h44, 1, 'h102));
    vecs.push_back(mk(1, 4, 'h104, 0, 0, 0, 1, 4, 1, 1, 3, 0, 4, 'h44, 0, 0));
    vecs.push_back(mk(1, 5, 'h105, 1, 6, 'h106, 1, 4, 0, 0, 4, 0, 4, 'h44, 1, 'h104));
    vecs.push_back(mk(1, 5, 'h105, 0, 0, 0, 0, 5, 0, 0, 4, 0, 4, 'h44, 0, 0));
    vecs.push_back(mki(0, 1, 3, 1, 1, 'h101, 1, 'h101));
    vecs.push_back(mki(0, 1, 2, 1, 2, 'h102, 0, 0));
    vecs.push_back(mki(0, 4, 1, 1, 3, 'h103, 1, 'h104));
    vecs.push_back(mki(0, 4, 0, 1, 4, 'h104, 1, 'h104));
    vecs.push_back(mki(0, 4, 0, 0, 4, 'h104, 0, 0));
    // address 0 is acknowledged but dropped
    vecs.push_back(mk(1, 0, 'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 'h104, 0, 0));
    vecs.push_back(mki(0, 0, 0, 0, 4, 'h104, 0, 0));
    vecs.push_back(mki(0, 0, 0, 0, 4, 'h104, 0, 0));
    // same-register pair: hazard and youngest bypass
    vecs.push_back(mk(1, 7, 'h11, 0, 0, 0, 1, 7, 1, 1, 0, 0, 4, 'h104, 0, 0));
    vecs.push_back(mk(1, 7, 'h22, 0, 0, 0, 1, 7, 1, 1, 1, 0, 4, 'h104, 1, 'h11));
    vecs.push_back(mki(1, 7, 2, 0, 4, 'h104, 1, 'h22));
    vecs.push_back(mki(1, 0, 2, 0, 4, 'h104, 0, 0));
    vecs.push_back(mki(1, 8, 2, 0, 4, 'h104, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 'h99, 1, 0, 0, 1, 2, 0, 4, 'h104, 0, 0));
    vecs.push_back(mki(0, 7, 2, 0, 4, 'h104, 1, 'h22));
    vecs.push_back(mki(0, 7, 1, 1, 7, 'h11, 1, 'h22));
    vecs.push_back(mki(0, 7, 0, 1, 7, 'h22, 1, 'h22));
    vecs.push_back(mki(0, 7, 0, 0, 7, 'h22, 0, 0));

    reset = 1'b1;
    wb_hold = 1'b0;
    Ard_chk = '0;
    drive_idle();
    #2;
    check("reset_count", -1, 32'(count), 0);
    check("reset_wren",  -1, 32'(WrEn), 0);
    check("reset_awr",   -1, 32'(Awr), 0);
    check("reset_din",   -1, Din, 0);
    @(negedge Clk);
    reset = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge Clk);
      alu_valid = vecs[r].av; alu_addr = vecs[r].aa; alu_data = vecs[r].ad;
      mem_valid = vecs[r].mv; mem_addr = vecs[r].ma; mem_data = vecs[r].md;
      wb_hold = vecs[r].hold; Ard_chk = vecs[r].chk;
      #1;
      check("alu_ready",   r, 32'(alu_ready),   32'(vecs[r].ear));
      check("mem_ready",   r, 32'(mem_ready),   32'(vecs[r].emr));
      check("count",       r, 32'(count),       32'(vecs[r].ecnt));
      check("WrEn",        r, 32'(WrEn),        32'(vecs[r].ewe));
      check("Awr",         r, 32'(Awr),         32'(vecs[r].eawr));
      check("Din",         r, Din,              vecs[r].edin);
      check("chk_pending", r, 32'(chk_pending), 32'(vecs[r].epend));
      check("chk_data",    r, chk_data,         exp_bypass(vecs[r].ecd));
    end

    // Async reset while a write is being issued and entries remain queued.
    @(negedge Clk);
    drive_idle();
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = AW'(8 + i); alu_data = DW'(32'h80 + i);
      @(negedge Clk);
    end
    drive_idle();
    wb_hold = 1'b0;
    @(negedge Clk);
    #1;
    check("pre_reset_wren",  100, 32'(WrEn), 1);
    check("pre_reset_count", 100, 32'(count), 2);
    wb_hold = 1'b1;
    Ard_chk = AW'(9);
    #2;
    reset = 1'b1;
    #1;
    check("async_count",   101, 32'(count), 0);
    check("async_wren",    101, 32'(WrEn), 0);
    check("async_awr",     101, 32'(Awr), 0);
    check("async_din",     101, Din, 0);
    check("async_pending", 101, 32'(chk_pending), 0);
    @(negedge Clk);
    reset = 1'b0;
    wb_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1;
      check("post_reset_wren",  102 + i, 32'(WrEn), 0);
      check("post_reset_count", 102 + i, 32'(count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side initiator for the Register_File write port (Awr/Din/WrEn); sits between the pipeline result sources and the register file.
- Accepts writeback requests from the ALU and memory stages over valid/ready and buffers them in a small FIFO.
- Drains the FIFO one write per cycle to the register file.
- Reports whether a read address still has an uncommitted write pending, so the read side can detect RAW hazards.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, 5, register address width
DW, 32, register data width

Ports:
Clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request valid
alu_ready  out  1  ALU request accepted this cycle
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
mem_valid  in  1  memory-load writeback request valid
mem_ready  out  1  memory request accepted this cycle
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
wb_hold  in  1  1 = do not drain FIFO this cycle
Awr  out  AW  register file write address (registered)
Din  out  DW  register file write data (registered)
WrEn  out  1  register file write enable (registered)
Ard_chk  in  AW  read address to check for a pending write
chk_pending  out  1  combinational: uncommitted write to Ard_chk exists
chk_data  out  DW  bypass data (see Optional Feature)
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, active-high): pointers = 0, count = 0, WrEn = 0, Awr = 0, Din = 0 immediately. Queued entries are discarded.
- Reset mid-operation: no write issues after reset asserts.
- Acceptance: at most one push per cycle; memory has priority.
  - mem_ready = ~full.
  - alu_ready = ~full & ~mem_valid.
  - full is registered occupancy (count == DEPTH). A same-cycle pop does not free a slot for a push in that cycle.
- Address 0: a request with addr == 0 completes its handshake (ready as above) but is not stored; count is unchanged. $0 is never written.
- Drain:
  - On each rising edge, if count > 0 and wb_hold == 0: pop head into Awr/Din and set WrEn = 1.
  - Otherwise WrEn = 0 and Awr/Din hold their previous values.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Latency: a request accepted at edge N into an empty FIFO with wb_hold = 0 loads the output registers at edge N+1. WrEn is high for the cycle N+1..N+2, and the register file commits at edge N+2.
- Ordering: strict FIFO. Two writes to the same register commit in acceptance order.
- Hazard check: chk_pending = (Ard_chk != 0) & (any valid FIFO entry has addr == Ard_chk, OR (WrEn & Awr == Ard_chk)).
- count wraps never. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Optional Feature:
- Macro RF_WBQ_BYPASS_EN.
- Defined: chk_data = data of the youngest pending write to Ard_chk. Priority is youngest FIFO entry first, then the output register when WrEn is high. chk_data = 0 when chk_pending = 0.
- Not defined: chk_data is tied to 0 and no comparator-to-data mux logic is built. chk_pending is unaffected.

Test Plan:
1. After reset, ALU push addr 5, data 0x000000A5 at edge N, wb_hold = 0 -> WrEn = 1, Awr = 5, Din = 0xA5 during cycle N+1..N+2 only; count returns to 0.
2. mem_valid and alu_valid both high with mem (3, 0x33) and alu (4, 0x44) -> cycle 1: mem_ready = 1, alu_ready = 0; ALU accepted the next cycle; writes appear on consecutive cycles as addr 3, then addr 4.
3. wb_hold = 1, push 4 entries (addrs 1-4) -> count = 4, both ready = 0, a 5th request is held off. Release hold -> four WrEn pulses in order 1, 2, 3, 4.
4. ALU push addr 0, data 0xFFFFFFFF -> alu_ready = 1, count stays 0, WrEn never asserts.
5. wb_hold = 1, queue (7, 0x11) then (7, 0x22).
   - Ard_chk = 7 -> chk_pending = 1, and chk_data = 0x22 with RF_WBQ_BYPASS_EN (0 without).
   - Ard_chk = 0 or 8 -> chk_pending = 0.
6. Queue 3 entries with wb_hold = 1, assert reset mid-cycle -> count = 0 and WrEn = 0 without waiting for a clock edge; no WrEn pulse after reset deasserts.
